// File: rtl/fetch_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and the instruction memory.
// The memory answers with Ack and Rdata in the same cycle as the request.
interface fetch_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  IMemReq;
    logic [DATA_WIDTH-1:0] IMemAddr;
    logic [DATA_WIDTH-1:0] IMemRdata;
    logic                  IMemAck;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemRdata,
        input  IMemAck
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemRdata,
        output IMemAck
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues fetches and holds the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the FetchCount/StallCount performance counters.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_if.master               imem,
    input  logic                  Stall,
    input  logic                  Jump,
    input  logic                  BranchEQ,
    input  logic                  BranchNE,
    input  logic                  Zero,
    input  logic [DATA_WIDTH-1:0] BranchImm,
    input  logic [25:0]           JumpIdx,
    output logic [DATA_WIDTH-1:0] IFID_Instr,
    output logic [DATA_WIDTH-1:0] IFID_PC4,
    output logic                  IFID_Valid,
    output logic [DATA_WIDTH-1:0] PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           FetchCount,
    output logic [31:0]           StallCount
`endif
);

    typedef enum logic [0:0] {S_REQ, S_HOLD} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
    logic                  ifid_valid_q, ifid_valid_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc4_q, skid_pc4_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] branch_target;
    logic [DATA_WIDTH-1:0] jump_target;
    logic                  take;
    logic                  ifid_load;

    assign pc_plus4      = pc_q + DATA_WIDTH'(4);
    assign branch_target = ifid_pc4_q + (BranchImm << 2);
    // Jump target assumes a 32-bit datapath: 4 + 26 + 2 bits.
    assign jump_target   = {ifid_pc4_q[DATA_WIDTH-1 -: 4], JumpIdx, 2'b00};
    assign take          = ifid_valid_q & ~Stall &
                           (Jump | (BranchEQ & Zero) | (BranchNE & ~Zero));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_load    = 1'b0;

        if (take) begin
            // Redirect wins over everything: skid and same-cycle ack data are dropped.
            pc_d         = Jump ? jump_target : branch_target;
            ifid_valid_d = 1'b0;
            state_d      = S_REQ;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem.IMemAck) begin
                        pc_d = pc_plus4;
                        if (!Stall) begin
                            ifid_instr_d = imem.IMemRdata;
                            ifid_pc4_d   = pc_plus4;
                            ifid_valid_d = 1'b1;
                            ifid_load    = 1'b1;
                        end else begin
                            skid_instr_d = imem.IMemRdata;
                            skid_pc4_d   = pc_plus4;
                            state_d      = S_HOLD;
                        end
                    end else if (!Stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc4_d   = skid_pc4_q;
                        ifid_valid_d = 1'b1;
                        ifid_load    = 1'b1;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    // Request is gated by reset so it drops the instant reset asserts.
    assign imem.IMemReq  = reset & (state_q == S_REQ);
    assign imem.IMemAddr = pc_q;
    assign IFID_Instr    = ifid_instr_q;
    assign IFID_PC4      = ifid_pc4_q;
    assign IFID_Valid    = ifid_valid_q;
    assign PC            = pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_event;

    assign stall_event = Stall | ((state_q == S_REQ) & ~imem.IMemAck);

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'b0, ifid_load};
        stall_cnt_d = stall_cnt_q + {31'b0, stall_event};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected IF/ID contents plus directed
// checks of PC redirect, stall/skid, and reset behaviour.
module tb_fetch_stage;
    localparam int unsigned DW  = 32;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall, Jump, BranchEQ, BranchNE, Zero;
    logic [31:0] BranchImm;
    logic [25:0] JumpIdx;
    logic [31:0] IFID_Instr, IFID_PC4, PC;
    logic        IFID_Valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, StallCount;
`endif

    fetch_if #(.DATA_WIDTH(DW)) imem ();

    fetch_stage #(.DATA_WIDTH(DW), .RESET_PC(RPC)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .imem       (imem.master),
        .Stall      (Stall),
        .Jump       (Jump),
        .BranchEQ   (BranchEQ),
        .BranchNE   (BranchNE),
        .Zero       (Zero),
        .BranchImm  (BranchImm),
        .JumpIdx    (JumpIdx),
        .IFID_Instr (IFID_Instr),
        .IFID_PC4   (IFID_PC4),
        .IFID_Valid (IFID_Valid),
        .PC         (PC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount (FetchCount),
        .StallCount (StallCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Apply one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic drive(input logic ack, input logic stall, input logic jmp, input logic beq,
                         input logic bne, input logic zero, input logic [31:0] imm,
                         input logic [25:0] idx);
        imem.IMemAck   = ack;
        imem.IMemRdata = ack ? mem(imem.IMemAddr) : 32'hBAD0_BAD0;
        Stall = stall; Jump = jmp; BranchEQ = beq; BranchNE = bne; Zero = zero;
        BranchImm = imm; JumpIdx = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        imem.IMemAck = 1'b0; Stall = 1'b0; Jump = 1'b0; BranchEQ = 1'b0; BranchNE = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
        exp_pc = RPC;
    endtask

    task automatic fetch_and_check(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{instr: mem(exp_pc), pc4: exp_pc + 32'd4});
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
            exp_pc += 32'd4;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++; $display("FAIL fetch_sb_empty: got empty queue want one entry");
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (IFID_Instr !== e.instr) begin
                    n_err++; $display("FAIL fetch_instr: got %h want %h", IFID_Instr, e.instr);
                end
                n_cmp++;
                if (IFID_PC4 !== e.pc4) begin
                    n_err++; $display("FAIL fetch_pc4: got %h want %h", IFID_PC4, e.pc4);
                end
            end
            n_cmp++;
            if (IFID_Valid !== 1'b1) begin
                n_err++; $display("FAIL fetch_valid: got %b want 1", IFID_Valid);
            end
            n_cmp++;
            if (PC !== exp_pc) begin
                n_err++; $display("FAIL fetch_pc: got %h want %h", PC, exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        imem.IMemAck = 1'b0; imem.IMemRdata = '0; Stall = 1'b0; Jump = 1'b0;
        BranchEQ = 1'b0; BranchNE = 1'b0; Zero = 1'b0; BranchImm = '0; JumpIdx = '0;
        #12;
        n_cmp++; if (imem.IMemReq !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem.IMemReq); end
        n_cmp++; if (PC !== RPC) begin n_err++; $display("FAIL rst_pc: got %h want %h", PC, RPC); end
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", IFID_Valid); end
        n_cmp++; if (IFID_Instr !== 32'd0) begin n_err++; $display("FAIL rst_instr: got %h want 0", IFID_Instr); end
        n_cmp++; if (IFID_PC4 !== 32'd0) begin n_err++; $display("FAIL rst_pc4: got %h want 0", IFID_PC4); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem.IMemReq !== 1'b1) begin n_err++; $display("FAIL rel_req: got %b want 1", imem.IMemReq); end
        n_cmp++; if (imem.IMemAddr !== RPC) begin n_err++; $display("FAIL rel_addr: got %h want %h", imem.IMemAddr, RPC); end
        exp_pc = RPC;
    endtask

    task automatic test_sequential();
        fetch_and_check(3);
        n_cmp++; if (PC !== 32'h0040_000C) begin n_err++; $display("FAIL seq_pc_end: got %h want 0040000c", PC); end
    endtask

    task automatic test_stall();
        exp_t held, e;
        held = '{instr: mem(exp_pc - 32'd4), pc4: exp_pc};
        sb.push_back('{instr: mem(exp_pc), pc4: exp_pc + 32'd4});
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        exp_pc += 32'd4;
        n_cmp++; if (imem.IMemReq !== 1'b0) begin n_err++; $display("FAIL stall_req: got %b want 0", imem.IMemReq); end
        n_cmp++; if (IFID_Instr !== held.instr) begin n_err++; $display("FAIL stall_hold1: got %h want %h", IFID_Instr, held.instr); end
        n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL stall_pc: got %h want %h", PC, exp_pc); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        n_cmp++; if (imem.IMemReq !== 1'b0) begin n_err++; $display("FAIL stall_req2: got %b want 0", imem.IMemReq); end
        n_cmp++; if (IFID_PC4 !== held.pc4) begin n_err++; $display("FAIL stall_hold2: got %h want %h", IFID_PC4, held.pc4); end
        n_cmp++; if (IFID_Valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", IFID_Valid); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_cmp++; if (IFID_Instr !== e.instr) begin n_err++; $display("FAIL unstall_instr: got %h want %h", IFID_Instr, e.instr); end
        n_cmp++; if (IFID_PC4 !== e.pc4) begin n_err++; $display("FAIL unstall_pc4: got %h want %h", IFID_PC4, e.pc4); end
        n_cmp++; if (IFID_Valid !== 1'b1) begin n_err++; $display("FAIL unstall_valid: got %b want 1", IFID_Valid); end
        n_cmp++; if (imem.IMemReq !== 1'b1) begin n_err++; $display("FAIL unstall_req: got %b want 1", imem.IMemReq); end
        n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL unstall_pc: got %h want %h", PC, exp_pc); end
        fetch_and_check(1);
    endtask

    task automatic test_bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid: got %b want 0", IFID_Valid); end
        n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL bubble_pc: got %h want %h", PC, exp_pc); end
        fetch_and_check(1);
    endtask

    task automatic test_branch_eq();
        pulse_reset();
        fetch_and_check(4);
        n_cmp++; if (IFID_PC4 !== 32'h0040_0010) begin n_err++; $display("FAIL beq_pre_pc4: got %h want 00400010", IFID_PC4); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 26'd0);
        n_cmp++; if (PC !== 32'h0040_0000) begin n_err++; $display("FAIL beq_pc: got %h want 00400000", PC); end
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL beq_valid: got %b want 0", IFID_Valid); end
        exp_pc = 32'h0040_0000;
        fetch_and_check(1);
    endtask

    task automatic test_branch_ne();
        exp_t e;
        sb.push_back('{instr: mem(exp_pc), pc4: exp_pc + 32'd4});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 26'd0);
        exp_pc += 32'd4;
        e = sb.pop_front();
        n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL bne_pc: got %h want %h", PC, exp_pc); end
        n_cmp++; if (IFID_Valid !== 1'b1) begin n_err++; $display("FAIL bne_valid: got %b want 1", IFID_Valid); end
        n_cmp++; if (IFID_Instr !== e.instr) begin n_err++; $display("FAIL bne_instr: got %h want %h", IFID_Instr, e.instr); end
    endtask

    task automatic test_jump();
        pulse_reset();
        fetch_and_check(2);
        n_cmp++; if (IFID_PC4 !== 32'h0040_0008) begin n_err++; $display("FAIL jmp_pre_pc4: got %h want 00400008", IFID_PC4); end
        // BranchEQ/Zero also set: the jump target must win.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 26'h0100003);
        n_cmp++; if (PC !== 32'h0040_000C) begin n_err++; $display("FAIL jmp_pc: got %h want 0040000c", PC); end
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL jmp_valid: got %b want 0", IFID_Valid); end
        n_cmp++; if (imem.IMemAddr !== 32'h0040_000C) begin n_err++; $display("FAIL jmp_addr: got %h want 0040000c", imem.IMemAddr); end
        exp_pc = 32'h0040_000C;
        fetch_and_check(1);
    endtask

    task automatic test_stall_branch();
        logic [31:0] p4;
        p4 = IFID_PC4;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8, 26'd0);
        exp_pc += 32'd4;
        n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL sbr_noredir_pc: got %h want %h", PC, exp_pc); end
        n_cmp++; if (IFID_Valid !== 1'b1) begin n_err++; $display("FAIL sbr_hold_valid: got %b want 1", IFID_Valid); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8, 26'd0);
        exp_pc = p4 + 32'd32;
        n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL sbr_take_pc: got %h want %h", PC, exp_pc); end
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL sbr_take_valid: got %b want 0", IFID_Valid); end
        n_cmp++; if (imem.IMemReq !== 1'b1) begin n_err++; $display("FAIL sbr_req: got %b want 1", imem.IMemReq); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL sbr_skid_drop: got %b want 0", IFID_Valid); end
        n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL sbr_after_pc: got %h want %h", PC, exp_pc); end
    endtask

    task automatic test_reset_hold();
        fetch_and_check(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        n_cmp++; if (imem.IMemReq !== 1'b0) begin n_err++; $display("FAIL rh_hold_req: got %b want 0", imem.IMemReq); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (imem.IMemReq !== 1'b0) begin n_err++; $display("FAIL rh_req: got %b want 0", imem.IMemReq); end
        n_cmp++; if (IFID_Valid !== 1'b0) begin n_err++; $display("FAIL rh_valid: got %b want 0", IFID_Valid); end
        n_cmp++; if (IFID_Instr !== 32'd0) begin n_err++; $display("FAIL rh_instr: got %h want 0", IFID_Instr); end
        n_cmp++; if (IFID_PC4 !== 32'd0) begin n_err++; $display("FAIL rh_pc4: got %h want 0", IFID_PC4); end
        n_cmp++; if (PC !== RPC) begin n_err++; $display("FAIL rh_pc: got %h want %h", PC, RPC); end
        imem.IMemAck = 1'b0; Stall = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
        exp_pc = RPC;
        #1;
        n_cmp++; if (imem.IMemAddr !== RPC) begin n_err++; $display("FAIL rh_addr: got %h want %h", imem.IMemAddr, RPC); end
        n_cmp++; if (imem.IMemReq !== 1'b1) begin n_err++; $display("FAIL rh_rel_req: got %b want 1", imem.IMemReq); end
        fetch_and_check(1);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        pulse_reset();
        n_cmp++; if (FetchCount !== 32'd0) begin n_err++; $display("FAIL perf_rst_fetch: got %0d want 0", FetchCount); end
        n_cmp++; if (StallCount !== 32'd0) begin n_err++; $display("FAIL perf_rst_stall: got %0d want 0", StallCount); end
        fetch_and_check(5);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        n_cmp++; if (FetchCount !== 32'd5) begin n_err++; $display("FAIL perf_fetch: got %0d want 5", FetchCount); end
        n_cmp++; if (StallCount !== 32'd2) begin n_err++; $display("FAIL perf_stall: got %0d want 2", StallCount); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_bubble();
        test_branch_eq();
        test_branch_ne();
        test_jump();
        test_stall_branch();
        test_reset_hold();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
